// File: rtl/text_writer.sv
// Text-mode writer: turns PUT/NEWLINE/CLEAR/HOME commands into name-table RAM writes
// and tracks the cursor. The full-table and single-row blanking sweeps run one write per cycle.
module text_writer #(
  parameter int         COLS  = 40,
  parameter int         ROWS  = 30,
  parameter logic [3:0] BLANK = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd,
  input  logic [3:0]  cmd_char,
  output logic        cmd_ready,
  output logic [3:0]  wdata,
  output logic [10:0] waddr,
  output logic        wenable,
  output logic        busy,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    LINECLR = 2'd2
  } state_t;

  localparam logic [1:0]  CMD_PUT     = 2'b00;
  localparam logic [1:0]  CMD_NEWLINE = 2'b01;
  localparam logic [1:0]  CMD_CLEAR   = 2'b10;
  localparam logic [1:0]  CMD_HOME    = 2'b11;
  localparam logic [5:0]  LAST_COL    = 6'(COLS - 1);
  localparam logic [4:0]  LAST_ROW    = 5'(ROWS - 1);
  localparam logic [5:0]  LINE_LAST   = 6'd63;
  localparam logic [10:0] TABLE_LAST  = 11'd2047;

  state_t      state_r, state_s;
  logic [5:0]  line_cnt_r, line_cnt_s;
  logic [10:0] clr_cnt_r, clr_cnt_s;
  logic [5:0]  col_r, col_s;
  logic [4:0]  row_r, row_s;
  logic [3:0]  wdata_r, wdata_s;
  logic [10:0] waddr_r, waddr_s;
  logic        wenable_r, wenable_s;
  logic        newline_s;
  logic [4:0]  row_inc_s;

  assign row_inc_s = (row_r == LAST_ROW) ? 5'd0 : row_r + 5'd1;

  // Next-state, cursor and write-port logic
  always_comb begin
    state_s    = state_r;
    line_cnt_s = line_cnt_r;
    clr_cnt_s  = clr_cnt_r;
    col_s      = col_r;
    row_s      = row_r;
    wdata_s    = wdata_r;
    waddr_s    = waddr_r;
    wenable_s  = 1'b0;
    newline_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_PUT: begin
              wenable_s = 1'b1;
              waddr_s   = {row_r, col_r};
              wdata_s   = cmd_char;
              if (col_r == LAST_COL) begin
                newline_s = 1'b1;
              end else begin
                col_s = col_r + 6'd1;
              end
            end
            CMD_NEWLINE: newline_s = 1'b1;
            CMD_CLEAR: begin
              state_s   = CLEAR;
              clr_cnt_s = 11'd0;
            end
            CMD_HOME: begin
              col_s = 6'd0;
              row_s = 5'd0;
            end
            default: state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        wenable_s = 1'b1;
        waddr_s   = clr_cnt_r;
        wdata_s   = BLANK;
        if (clr_cnt_r == TABLE_LAST) begin
          state_s   = IDLE;
          clr_cnt_s = 11'd0;
          col_s     = 6'd0;
          row_s     = 5'd0;
        end else begin
          clr_cnt_s = clr_cnt_r + 11'd1;
        end
      end
      LINECLR: begin
        wenable_s = 1'b1;
        waddr_s   = {row_r, line_cnt_r};
        wdata_s   = BLANK;
        if (line_cnt_r == LINE_LAST) begin
          state_s    = IDLE;
          line_cnt_s = 6'd0;
        end else begin
          line_cnt_s = line_cnt_r + 6'd1;
        end
      end
      default: begin
        state_s   = CLEAR;
        clr_cnt_s = 11'd0;
      end
    endcase
    // The row sweep targets the row the cursor moves onto
    if (newline_s) begin
      col_s      = 6'd0;
      row_s      = row_inc_s;
      state_s    = LINECLR;
      line_cnt_s = 6'd0;
    end else begin
      line_cnt_s = line_cnt_s;
    end
  end

  // State and output registers; reset restarts the full clear sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= CLEAR;
      line_cnt_r <= 6'd0;
      clr_cnt_r  <= 11'd0;
      col_r      <= 6'd0;
      row_r      <= 5'd0;
      wdata_r    <= 4'h0;
      waddr_r    <= 11'd0;
      wenable_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      line_cnt_r <= line_cnt_s;
      clr_cnt_r  <= clr_cnt_s;
      col_r      <= col_s;
      row_r      <= row_s;
      wdata_r    <= wdata_s;
      waddr_r    <= waddr_s;
      wenable_r  <= wenable_s;
    end
  end

  assign cmd_ready  = (state_r == IDLE) && !rst;
  assign busy       = (state_r != IDLE) || rst;
  assign wdata      = wdata_r;
  assign waddr      = waddr_r;
  assign wenable    = wenable_r;
  assign cursor_col = col_r;
  assign cursor_row = row_r;

endmodule

// File: tb/tb_text_writer.sv
// Bench for text_writer: a cursor/write model feeds an expected-write queue that a
// monitor drains on every wenable pulse; a command table plus sweep/reset sequences.
module tb_text_writer;
  localparam int         COLS  = 40;
  localparam int         ROWS  = 30;
  localparam logic [3:0] BLANK = 4'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [3:0]  cmd_char = 4'h0;
  logic        cmd_ready, wenable, busy;
  logic [3:0]  wdata;
  logic [10:0] waddr;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;

  text_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_char(cmd_char),
    .cmd_ready(cmd_ready), .wdata(wdata), .waddr(waddr), .wenable(wenable),
    .busy(busy), .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] addr;
    logic [3:0]  data;
  } wr_t;

  typedef struct {
    logic [1:0] c;
    logic [3:0] ch;
    int         col;
    int         row;
  } vec_t;

  wr_t wq[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_wr  = 0;
  int  m_col = 0;
  int  m_row = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (wenable === 1'b1) begin
      wr_t e;
      n_wr++;
      n_cmp++;
      if (wq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", waddr, wdata);
      end else begin
        e = wq.pop_front();
        if ({waddr, wdata} !== e) begin
          n_bad++;
          $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h",
                   waddr, wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic m_newline;
    m_col = 0;
    m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
    for (int i = 0; i < 64; i++) wq.push_back(wr_t'{addr: 11'(m_row * 64 + i), data: BLANK});
  endtask

  task automatic m_clear;
    for (int i = 0; i < 2048; i++) wq.push_back(wr_t'{addr: 11'(i), data: BLANK});
    m_col = 0;
    m_row = 0;
  endtask

  task automatic model(input logic [1:0] c, input logic [3:0] ch);
    case (c)
      2'b00: begin
        wq.push_back(wr_t'{addr: 11'(m_row * 64 + m_col), data: ch});
        if (m_col == COLS - 1) m_newline();
        else m_col++;
      end
      2'b01: m_newline();
      2'b10: m_clear();
      default: begin m_col = 0; m_row = 0; end
    endcase
  endtask

  // Holds cmd_valid until the command is accepted
  task automatic send(input logic [1:0] c, input logic [3:0] ch);
    int k;
    model(c, ch);
    cmd = c;
    cmd_char = ch;
    cmd_valid = 1'b1;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 5000) begin
      step();
      k++;
    end
    if (k >= 5000) check("accept_timeout", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int k;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 4000) begin
      step();
      k++;
    end
    check("wait_idle", 32'(cmd_ready), 32'd1);
  endtask

  vec_t tbl[8];

  initial begin
    int k;
    int low;
    int snap;
    tbl[0] = '{2'b00, 4'h5, 1, 0};
    tbl[1] = '{2'b00, 4'hA, 2, 0};
    tbl[2] = '{2'b01, 4'h0, 0, 1};
    tbl[3] = '{2'b00, 4'h3, 1, 1};
    tbl[4] = '{2'b11, 4'h0, 0, 0};
    tbl[5] = '{2'b00, 4'hF, 1, 0};
    tbl[6] = '{2'b10, 4'h0, 0, 0};
    tbl[7] = '{2'b01, 4'h0, 0, 1};

    // Reset values
    rst = 1'b1;
    repeat (3) step();
    check("rst_wenable", 32'(wenable), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_col", 32'(cursor_col), 32'd0);
    check("rst_row", 32'(cursor_row), 32'd0);

    // Power-up clear sweep
    m_clear();
    n_wr = 0;
    rst = 1'b0;
    wait_idle();
    check("init_writes", 32'(n_wr), 32'd2048);
    check("init_queue", 32'(wq.size()), 32'd0);
    check("init_busy", 32'(busy), 32'd0);
    check("init_col", 32'(cursor_col), 32'd0);
    check("init_row", 32'(cursor_row), 32'd0);

    // Command table
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].c, tbl[i].ch);
      wait_idle();
      check("tbl_col", 32'(cursor_col), 32'(tbl[i].col));
      check("tbl_row", 32'(cursor_row), 32'(tbl[i].row));
      check("tbl_queue", 32'(wq.size()), 32'd0);
    end

    // PUT in the last column wraps and blanks the next row
    send(2'b11, 4'h0);
    for (int i = 0; i < 3; i++) begin send(2'b01, 4'h0); wait_idle(); end
    for (int i = 0; i < 39; i++) send(2'b00, 4'h1);
    check("a_col", 32'(cursor_col), 32'd39);
    check("a_row", 32'(cursor_row), 32'd3);
    send(2'b00, 4'h7);
    check("a_busy", 32'(busy), 32'd1);
    low = 0;
    while (cmd_ready !== 1'b1 && low < 200) begin
      low++;
      step();
    end
    check("a_ready_low", 32'(low), 32'd64);
    check("a_col2", 32'(cursor_col), 32'd0);
    check("a_row2", 32'(cursor_row), 32'd4);
    check("a_queue", 32'(wq.size()), 32'd0);

    // NEWLINE on the last row wraps to row 0
    send(2'b11, 4'h0);
    for (int i = 0; i < 29; i++) begin send(2'b01, 4'h0); wait_idle(); end
    for (int i = 0; i < 10; i++) send(2'b00, 4'h2);
    check("b_row", 32'(cursor_row), 32'd29);
    send(2'b01, 4'h0);
    wait_idle();
    check("b_col", 32'(cursor_col), 32'd0);
    check("b_row2", 32'(cursor_row), 32'd0);
    check("b_queue", 32'(wq.size()), 32'd0);

    // PUT held during LINECLR is taken once, after the sweep
    snap = n_wr;
    send(2'b01, 4'h0);
    send(2'b00, 4'h9);
    wait_idle();
    check("c_writes", 32'(n_wr - snap), 32'd65);
    check("c_col", 32'(cursor_col), 32'd1);
    check("c_queue", 32'(wq.size()), 32'd0);

    // Reset in the middle of the clear sweep
    rst = 1'b1;
    step();
    step();
    wq.delete();
    m_clear();
    n_wr = 0;
    rst = 1'b0;
    k = 0;
    while (n_wr < 1000 && k < 3000) begin
      step();
      k++;
    end
    rst = 1'b1;
    check("d_queue_at_abort", 32'(wq.size()), 32'd1048);
    step();
    check("d_wenable", 32'(wenable), 32'd0);
    check("d_waddr", 32'(waddr), 32'd0);
    check("d_busy", 32'(busy), 32'd1);
    check("d_ready", 32'(cmd_ready), 32'd0);
    step();
    wq.delete();
    m_clear();
    n_wr = 0;
    rst = 1'b0;
    wait_idle();
    check("d_writes", 32'(n_wr), 32'd2048);
    check("d_queue", 32'(wq.size()), 32'd0);
    check("d_col", 32'(cursor_col), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
